// File: rtl/mips_syscall_pkg.sv
// mips_syscall_pkg: shared state encoding, service codes and BCD helpers for syscall_unit
package mips_syscall_pkg;
  typedef enum logic [2:0] {IDLE, CONV, EMIT, CHAR, DONE, HALT} state_t;
  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_EXIT = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SVC_EXIT2 = 32'd17;
  localparam logic [31:0] SYSCALL_WORD_DEF = 32'h0000000C;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  function automatic logic [39:0] bcd_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) r[i*4 +: 4] = (r[i*4 +: 4] > 4'd4) ? r[i*4 +: 4] + 4'd3 : r[i*4 +: 4];
    return r;
  endfunction
  // index of the most significant non-zero digit, 0 when the value is zero
  function automatic logic [3:0] msd_index(input logic [39:0] b);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = (b[i*4 +: 4] != 4'd0) ? 4'(i) : r;
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 32-bit binary to 10-digit BCD, one double-dabble step per cycle, 32 cycles
module bin2bcd_seq
  import mips_syscall_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd
);
  logic [31:0] sh_q, sh_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    sh_d = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    if (start) begin
      sh_d = value;
      bcd_d = '0;
      cnt_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, sh_d} = {bcd_adjust(bcd_q)[38:0], sh_q, 1'b0};
      cnt_d = cnt_q + 5'd1;
      busy_d = cnt_q != 5'd31;
    end
  end
  assign busy = busy_q;
  assign done = busy_q && cnt_q == 5'd31;
  assign bcd = bcd_q;
endmodule

// File: rtl/syscall_unit.sv
// syscall_unit: services MIPS syscall instructions (print int/char, exit) while stalling the core
module syscall_unit
  import mips_syscall_pkg::*;
#(
  parameter logic [31:0] SYSCALL_WORD = SYSCALL_WORD_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic [31:0]      pc,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  output logic             stall,
  output logic             halted,
  output logic [31:0]      exit_code,
  output logic [31:0]      trap_pc,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             bad_service,
  output logic [CNT_W-1:0] svc_count
);
  state_t state_q, state_d;
  logic [31:0] trap_pc_q, trap_pc_d, exit_code_q, exit_code_d;
  logic [7:0] char_q, char_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic bad_q, bad_d, minus_q, minus_d, first_q, first_d;
  logic [3:0] idx_q, idx_d, cur_idx, digit;
  logic trig, xfer, bcd_start, bcd_busy, bcd_done;
  logic [39:0] bcd;
  bin2bcd_seq u_bcd (
    .clk(clk), .rst(rst), .start(bcd_start), .value(a0[31] ? -a0 : a0),
    .busy(bcd_busy), .done(bcd_done), .bcd(bcd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      trap_pc_q <= '0;
      exit_code_q <= '0;
      char_q <= '0;
      cnt_q <= '0;
      bad_q <= 1'b0;
      minus_q <= 1'b0;
      first_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      trap_pc_q <= trap_pc_d;
      exit_code_q <= exit_code_d;
      char_q <= char_d;
      cnt_q <= cnt_d;
      bad_q <= bad_d;
      minus_q <= minus_d;
      first_q <= first_d;
      idx_q <= idx_d;
    end
  end
  always_comb begin
    trig = inst == SYSCALL_WORD;
    xfer = tx_valid && tx_ready;
    cur_idx = first_q ? msd_index(bcd) : idx_q;
    bcd_start = state_q == IDLE && trig && v0 == SVC_PRINT_INT;
    state_d = state_q;
    trap_pc_d = trap_pc_q;
    exit_code_d = exit_code_q;
    char_d = char_q;
    bad_d = bad_q;
    minus_d = minus_q;
    first_d = first_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (trig) begin
        trap_pc_d = pc;
        char_d = a0[7:0];
        minus_d = a0[31];
        first_d = 1'b1;
        if (v0 == SVC_PRINT_INT) state_d = CONV;
        else if (v0 == SVC_PRINT_CHAR) state_d = CHAR;
        else if (v0 == SVC_EXIT || v0 == SVC_EXIT2) begin
          state_d = HALT;
          exit_code_d = (v0 == SVC_EXIT2) ? a0 : 32'd0;
        end else begin
          state_d = DONE;
          bad_d = 1'b1;
        end
      end
      CONV: if (bcd_done || !bcd_busy) state_d = EMIT;
      EMIT: if (xfer) begin
        if (minus_q) minus_d = 1'b0;
        else if (cur_idx == 4'd0) state_d = DONE;
        else begin
          idx_d = cur_idx - 4'd1;
          first_d = 1'b0;
        end
      end
      CHAR: if (xfer) state_d = DONE;
      DONE: state_d = IDLE;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    // both normal completion and exit entry count as one serviced syscall
    cnt_d = (state_d == DONE || (state_d == HALT && state_q != HALT)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    digit = 4'(bcd >> {cur_idx, 2'b00});
    stall = (state_q == IDLE) ? trig : state_q != DONE;
    tx_valid = state_q == EMIT || state_q == CHAR;
    tx_data = (state_q == CHAR) ? char_q :
              (state_q == EMIT) ? (minus_q ? ASCII_MINUS : ASCII_ZERO + {4'h0, digit}) : 8'h00;
    halted = state_q == HALT;
    exit_code = exit_code_q;
    trap_pc = trap_pc_q;
    bad_service = bad_q;
    svc_count = cnt_q;
  end
endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: randomized self-checking bench against a string-level model of syscall output
module tb_syscall_unit;
  localparam logic [31:0] SYS = 32'h0000000C;
  localparam logic [31:0] NOP = 32'h00000000;
  logic clk = 1'b0, rst, stall, halted, tx_valid, tx_ready, bad_service;
  logic [31:0] inst, pc, v0, a0, exit_code, trap_pc;
  logic [7:0] tx_data;
  logic [15:0] svc_count;
  int vectors = 0, miscompares = 0, exp_count = 0;
  bit exp_bad = 0;
  always #5 clk = ~clk;
  syscall_unit dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .v0(v0), .a0(a0), .stall(stall),
    .halted(halted), .exit_code(exit_code), .trap_pc(trap_pc), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .bad_service(bad_service), .svc_count(svc_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    inst = NOP;
    v0 = '0;
    a0 = '0;
    pc = '0;
    tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_flags", {28'd0, stall, halted, tx_valid, bad_service}, 32'd0);
    chk("rst_exit_code", exit_code, 32'd0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_svc_count", {16'd0, svc_count}, 32'd0);
    exp_count = 0;
    exp_bad = 0;
  endtask
  // mode: 0 always ready, 1 random ready, 2 ready held low for the first 5 valid cycles
  task automatic run_svc(input logic [31:0] sv, input logic [31:0] sa, input logic [31:0] spc,
                         input int mode, input bit b2b);
    byte exp_q[$], got_q[$];
    string s;
    int stall_hi = 0, waits = 0, first_v = -1, vseen = 0;
    bit done_seen = 0, is_int = (sv == 32'd1), is_chr = (sv == 32'd11);
    logic pv = 1'b0, pr = 1'b1;
    logic [7:0] pd = 8'h00;
    s = $sformatf("%0d", $signed(sa));
    if (is_int) for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (is_chr) exp_q.push_back(sa[7:0]);
    inst = SYS;
    v0 = sv;
    a0 = sa;
    pc = spc;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      #1;
      if (pv && !pr) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_data", {24'd0, tx_data}, {24'd0, pd});
      end
      tx_ready = (mode == 0) ? 1'b1 : (mode == 2) ? (vseen >= 5) : ($urandom_range(0, 3) != 0);
      #1;
      if (tx_valid && first_v < 0) first_v = c;
      if (tx_valid) vseen++;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (tx_valid && !tx_ready) waits++;
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
      if (stall) stall_hi++;
      else begin
        done_seen = 1;
        if (!b2b) inst = NOP;
      end
      @(negedge clk);
    end
    chk("svc_done", {31'd0, done_seen}, 32'd1);
    if (!is_int && !is_chr) exp_bad = 1;
    exp_count++;
    chk("nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk("byte", (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    chk("stall_cycles", stall_hi, 1 + (is_int ? 32 : 0) + exp_q.size() + waits);
    if (is_int || is_chr) chk("first_valid", first_v, is_int ? 33 : 1);
    if (mode == 2) chk("ready_waits", waits, 5);
    #1;
    chk("svc_count", {16'd0, svc_count}, {16'd0, 16'(exp_count)});
    chk("bad_service", {31'd0, bad_service}, {31'd0, exp_bad});
    chk("not_halted", {31'd0, halted}, 32'd0);
    chk("trap_pc", trap_pc, spc);
  endtask
  task automatic run_halt(input logic [31:0] sv, input logic [31:0] sa, input logic [31:0] spc);
    int bad_cyc = 0;
    inst = SYS;
    v0 = sv;
    a0 = sa;
    pc = spc;
    for (int c = 0; c < 120; c++) begin
      #1;
      tx_ready = 1'($urandom);
      if (!stall || tx_valid) bad_cyc++;
      if (c > 0 && !halted) bad_cyc++;
      if (c == 1) inst = NOP;
      @(negedge clk);
    end
    exp_count++;
    chk("halt_cycles", bad_cyc, 0);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("exit_code", exit_code, (sv == 32'd17) ? sa : 32'd0);
    chk("halt_trap_pc", trap_pc, spc);
    chk("halt_svc_count", {16'd0, svc_count}, {16'd0, 16'(exp_count)});
    chk("halt_bad", {31'd0, bad_service}, {31'd0, exp_bad});
    do_reset();
  endtask
  initial begin
    logic [31:0] r, bv;
    do_reset();
    run_svc(32'd1, 32'd0, 32'h0040_0000, 0, 0);
    run_svc(32'd1, 32'h8000_0000, 32'h0040_0004, 0, 1);
    run_svc(32'd1, 32'd1234567, 32'h0040_0008, 0, 0);
    run_svc(32'd11, 32'h41, 32'h0040_000C, 2, 0);
    run_halt(32'd17, 32'd42, 32'h0040_0020);
    run_svc(32'd99, 32'd7, 32'h0040_0030, 0, 0);
    run_halt(32'd10, 32'd5, 32'h0040_0034);
    inst = SYS;
    v0 = 32'd1;
    a0 = -32'sd5;
    pc = 32'h0040_0040;
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("conv_stall", {31'd0, stall}, 32'd1);
    do_reset();
    run_svc(32'd1, -32'sd5, 32'h0040_0040, 0, 0);
    for (int k = 0; k < 25; k++) begin
      int sel;
      sel = $urandom_range(0, 5);
      case ($urandom_range(0, 4))
        0: r = $urandom;
        1: r = $urandom_range(0, 99);
        2: r = -$urandom_range(1, 99);
        3: r = 32'h7FFF_FFFF;
        default: r = 32'h8000_0000;
      endcase
      do bv = $urandom; while (bv == 1 || bv == 10 || bv == 11 || bv == 17);
      if (sel <= 2) run_svc(32'd1, r, $urandom, $urandom_range(0, 1), 1'($urandom));
      else if (sel == 3) run_svc(32'd11, $urandom_range(32'h20, 32'h7E), $urandom, $urandom_range(0, 1), 1'($urandom));
      else if (sel == 4) run_svc(bv, r, $urandom, 1, 1'($urandom));
      else run_svc(32'd1, r, $urandom, 1, 0);
    end
    run_halt($urandom_range(0, 1) ? 32'd10 : 32'd17, $urandom, $urandom);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
